// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB3 master controller.
// Optional watchdog is enabled with APB_TIMEOUT_EN.
package apb_master_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } cmd_t;

  function automatic int cmd_w(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

  function automatic cmd_t pack_cmd(
    input logic                  write,
    input logic [DEF_ADDR_W-1:0] addr,
    input logic [DEF_DATA_W-1:0] wdata
  );
    cmd_t c;
    c.write = write;
    c.addr  = addr;
    c.wdata = wdata;
    return c;
  endfunction

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Command/response port and APB bus bundle for apb_master_ctrl.
// master = controller view, slave = host plus APB target view.
interface apb_master_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              busy;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic              pslverr;
  logic [DATA_W-1:0] prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_rdata,
    output rsp_err, rsp_timeout, busy,
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, pslverr, prdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_rdata,
    input  rsp_err, rsp_timeout, busy,
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO, DEPTH a power of two.
// Wrap bit on each pointer separates full from empty.
module apb_cmd_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full = (wr_ptr[PW] != rd_ptr[PW]) &&
                (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[PW-1:0]];

  // pointer update; reset flushes contents
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // storage array, contents irrelevant while empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end
endmodule

// File: rtl/apb_master_ctrl.sv
// APB3 master: command FIFO feeding a SETUP/ACCESS FSM.
// Define APB_TIMEOUT_EN to add the ACCESS watchdog.
module apb_master_ctrl
  import apb_master_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input logic               pclk,
  input logic               preset,
  apb_master_ctrl_if.master bus
);
  localparam int CW = cmd_w(ADDR_W, DATA_W);

  state_t          state;
  state_t          state_d;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            done;
  logic            to_hit;
  logic [CW-1:0]   head;

  assign push          = bus.cmd_valid && !full;
  assign bus.cmd_ready = !full;
  assign bus.busy      = (state != IDLE) || !empty;

  apb_cmd_fifo #(
    .WIDTH (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (pclk),
    .rst   (preset),
    .push  (push),
    .pop   (pop),
    .din   ({bus.cmd_write, bus.cmd_addr, bus.cmd_wdata}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] acc_cnt;

  // stalled ACCESS cycles; held at zero outside ACCESS
  always_ff @(posedge pclk) begin
    if (preset || state != ACCESS) acc_cnt <= '0;
    else if (!bus.pready)          acc_cnt <= acc_cnt + TW'(1);
  end

  assign to_hit = (state == ACCESS) && !bus.pready &&
                  (acc_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge pclk) begin
    if (preset) state <= IDLE;
    else        state <= state_d;
  end

  // next state, FIFO pop and completion strobe
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          state_d = SETUP;
          pop     = 1'b1;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (bus.pready || to_hit) begin
          done = 1'b1;
          if (!empty) begin
            state_d = SETUP;
            pop     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // APB outputs, address/data held until next load
  always_ff @(posedge pclk) begin
    if (preset) begin
      bus.psel    <= 1'b0;
      bus.penable <= 1'b0;
      bus.pwrite  <= 1'b0;
      bus.paddr   <= '0;
      bus.pwdata  <= '0;
    end else begin
      bus.psel    <= (state_d != IDLE);
      bus.penable <= (state_d == ACCESS);
      if (pop) begin
        bus.pwrite <= head[CW-1];
        bus.paddr  <= head[DATA_W +: ADDR_W];
        bus.pwdata <= head[DATA_W-1:0];
      end
    end
  end

  // response capture; fields hold between pulses
  always_ff @(posedge pclk) begin
    if (preset) begin
      bus.rsp_valid   <= 1'b0;
      bus.rsp_write   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      bus.rsp_valid <= done;
      if (done) begin
        bus.rsp_write   <= bus.pwrite;
        bus.rsp_err     <= bus.pready ? bus.pslverr : 1'b1;
        bus.rsp_timeout <= to_hit;
        bus.rsp_rdata   <= (bus.pready && !bus.pwrite) ?
                           bus.prdata : '0;
      end
    end
  end
endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl.
// Timeout cases are built only with APB_TIMEOUT_EN.
module tb_apb_master_ctrl;
  localparam int AW = 8;
  localparam int DW = 8;

  logic pclk = 1'b0;
  logic preset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  apb_master_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  typedef struct {
    logic       w;
    logic [7:0] rd;
    logic       err;
    logic       to;
    int         t;
  } rsp_s;

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
  } xfer_s;

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    int         waits;
    logic [7:0] prd;
    logic       perr;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;

  rsp_s  got[$];
  rsp_s  exp_q[$];
  xfer_s seen[$];
  xfer_s expx[$];

  logic [7:0] smem [256];
  logic [7:0] rmem [256];

  bit         cfg_mem = 1'b0;
  bit         cfg_rand = 1'b0;
  int         cfg_wait = 0;
  logic [7:0] cfg_rdata = '0;
  logic       cfg_err = 1'b0;
  int         wcnt = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic step();
    @(negedge pclk);
    #1;
  endtask

  // reference: target returns stored byte, errors at F0..FF
  task automatic model_cmd(input logic w,
                           input logic [7:0] a,
                           input logic [7:0] d);
    rsp_s  r;
    xfer_s x;
    r.w   = w;
    r.err = (a >= 8'hF0);
    r.to  = 1'b0;
    r.rd  = w ? 8'h00 : rmem[a];
    r.t   = 0;
    if (w && !r.err) rmem[a] = d;
    x.w = w;
    x.a = a;
    x.d = d;
    exp_q.push_back(r);
    expx.push_back(x);
  endtask

  task automatic compare_all(input string tag, input int settle);
    rsp_s  g;
    rsp_s  e;
    xfer_s gx;
    xfer_s ex;
    for (int k = 0; k < 3000 && got.size() < exp_q.size(); k++)
      step();
    repeat (settle) step();
    check({tag, "_count"}, got.size(), exp_q.size());
    while (got.size() > 0 && exp_q.size() > 0) begin
      g = got.pop_front();
      e = exp_q.pop_front();
      check({tag, "_rsp_write"}, g.w, e.w);
      check({tag, "_rsp_rdata"}, g.rd, e.rd);
      check({tag, "_rsp_err"}, g.err, e.err);
      check({tag, "_rsp_timeout"}, g.to, e.to);
    end
    while (seen.size() > 0 && expx.size() > 0) begin
      gx = seen.pop_front();
      ex = expx.pop_front();
      check({tag, "_pwrite"}, gx.w, ex.w);
      check({tag, "_paddr"}, gx.a, ex.a);
      if (ex.w) check({tag, "_pwdata"}, gx.d, ex.d);
    end
    got.delete();
    exp_q.delete();
    seen.delete();
    expx.delete();
  endtask

  task automatic run_one(input logic w,
                         input logic [7:0] a,
                         input logic [7:0] d,
                         output int lat,
                         output int pen);
    int t0;
    lat = -1;
    pen = 0;
    got.delete();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    t0 = cyc + 1;
    step();
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 80 && got.size() == 0; k++) begin
      step();
      if (bus.penable) pen++;
    end
    if (got.size() != 0) lat = got[0].t - t0;
  endtask

  // response monitor
  initial begin
    forever begin
      @(negedge pclk);
      if (bus.rsp_valid)
        got.push_back('{bus.rsp_write, bus.rsp_rdata,
                        bus.rsp_err, bus.rsp_timeout, cyc});
    end
  end

  // APB target with programmable wait states
  initial begin
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = '0;
    forever begin
      @(negedge pclk);
      if (bus.psel && bus.penable) begin
        if (wcnt > 0) begin
          wcnt--;
          bus.pready  = 1'b0;
          bus.pslverr = 1'b1;
          bus.prdata  = 8'($urandom);
        end else begin
          bus.pready = 1'b1;
          if (cfg_mem) begin
            bus.prdata  = smem[bus.paddr];
            bus.pslverr = (bus.paddr >= 8'hF0);
            if (bus.pwrite && !bus.pslverr)
              smem[bus.paddr] = bus.pwdata;
          end else begin
            bus.prdata  = cfg_rdata;
            bus.pslverr = cfg_err;
          end
          seen.push_back('{bus.pwrite, bus.paddr, bus.pwdata});
        end
      end else begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'b1;
        bus.prdata  = 8'($urandom);
        wcnt = cfg_rand ? int'($urandom_range(0, 3)) : cfg_wait;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[5];
    int   t0;
    int   lat;
    int   pen;
    int   drops;
    int   n;
    logic pend;

    vt[0] = '{1'b1, 8'h04, 8'hA5, 0, 8'h77, 1'b0, 8'h00, 1'b0};
    vt[1] = '{1'b0, 8'h10, 8'h00, 2, 8'h3C, 1'b0, 8'h3C, 1'b0};
    vt[2] = '{1'b1, 8'h20, 8'h5A, 1, 8'h99, 1'b1, 8'h00, 1'b1};
    vt[3] = '{1'b0, 8'h33, 8'h00, 0, 8'hC3, 1'b1, 8'hC3, 1'b1};
    vt[4] = '{1'b0, 8'h7F, 8'h00, 3, 8'h00, 1'b0, 8'h00, 1'b0};

    for (int i = 0; i < 256; i++) begin
      smem[i] = 8'(i * 3 + 1);
      rmem[i] = 8'(i * 3 + 1);
    end

    // reset with a command offered
    preset        = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h55;
    bus.cmd_wdata = 8'hFF;
    repeat (3) step();
    check("rst_psel", bus.psel, 0);
    check("rst_penable", bus.penable, 0);
    check("rst_pwrite", bus.pwrite, 0);
    check("rst_paddr", bus.paddr, 0);
    check("rst_pwdata", bus.pwdata, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    preset        = 1'b0;
    bus.cmd_valid = 1'b0;
    repeat (4) step();
    check("post_rst_psel", bus.psel, 0);
    check("post_rst_ready", bus.cmd_ready, 1);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_norsp", got.size(), 0);

    // single-command vectors
    cfg_mem = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cfg_wait  = vt[i].waits;
      cfg_rdata = vt[i].prd;
      cfg_err   = vt[i].perr;
      got.delete();
      seen.delete();
      bus.cmd_valid = 1'b1;
      bus.cmd_write = vt[i].w;
      bus.cmd_addr  = vt[i].a;
      bus.cmd_wdata = vt[i].d;
      t0 = cyc + 1;
      step();
      bus.cmd_valid = 1'b0;
      check($sformatf("v%0d_e0_psel", i), bus.psel, 0);
      step();
      check($sformatf("v%0d_setup_psel", i), bus.psel, 1);
      check($sformatf("v%0d_setup_pen", i), bus.penable, 0);
      check($sformatf("v%0d_paddr", i), bus.paddr, vt[i].a);
      check($sformatf("v%0d_pwrite", i), bus.pwrite, vt[i].w);
      if (vt[i].w)
        check($sformatf("v%0d_pwdata", i), bus.pwdata, vt[i].d);
      step();
      check($sformatf("v%0d_acc_psel", i), bus.psel, 1);
      check($sformatf("v%0d_acc_pen", i), bus.penable, 1);
      for (int k = 0; k < 20 && got.size() == 0; k++) step();
      check($sformatf("v%0d_rsp_seen", i), got.size() != 0, 1);
      if (got.size() != 0) begin
        check($sformatf("v%0d_latency", i), got[0].t - t0,
              3 + vt[i].waits);
        check($sformatf("v%0d_rsp_write", i), got[0].w, vt[i].w);
        check($sformatf("v%0d_rsp_rdata", i), got[0].rd,
              vt[i].exp_rd);
        check($sformatf("v%0d_rsp_err", i), got[0].err,
              vt[i].exp_err);
        check($sformatf("v%0d_rsp_to", i), got[0].to, 0);
      end
      step();
      check($sformatf("v%0d_pulse", i), bus.rsp_valid, 0);
      check($sformatf("v%0d_hold_rd", i), bus.rsp_rdata,
            vt[i].exp_rd);
      check($sformatf("v%0d_idle", i), bus.busy, 0);
      step();
    end

    // back-to-back, zero wait states
    got.delete();
    seen.delete();
    cfg_mem  = 1'b1;
    cfg_wait = 0;
    for (int i = 0; i < 3; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 8'(8'h50 + i);
      bus.cmd_wdata = 8'(8'hB0 + i);
      model_cmd(1'b1, 8'(8'h50 + i), 8'(8'hB0 + i));
      step();
    end
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 40 && got.size() < 3; k++) step();
    check("b2b_seen", got.size(), 3);
    if (got.size() >= 3) begin
      check("b2b_gap1", got[1].t - got[0].t, 2);
      check("b2b_gap2", got[2].t - got[1].t, 2);
    end
    compare_all("b2b", 4);

    // fill the FIFO while the first transfer stalls
    cfg_wait = 6;
    for (int i = 0; i < 5; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_write = (i == 2 || i == 3) ? 1'b0 : 1'b1;
      bus.cmd_addr  = 8'(8'h40 + (i % 2));
      bus.cmd_wdata = 8'(8'h11 * (i + 1));
      check($sformatf("fill_ready%0d", i), bus.cmd_ready, 1);
      model_cmd(bus.cmd_write, bus.cmd_addr, bus.cmd_wdata);
      step();
    end
    check("full_ready", bus.cmd_ready, 0);
    bus.cmd_addr = 8'h4F;
    step();
    check("full_ready_hold", bus.cmd_ready, 0);
    bus.cmd_valid = 1'b0;
    drops = 0;
    for (int k = 0; k < 200 && got.size() < 5; k++) begin
      step();
      if (got.size() < 5 && !bus.psel) drops++;
    end
    check("fill_psel_drops", drops, 0);
    compare_all("fill", 20);

    // randomized traffic against the reference
    cfg_rand = 1'b1;
    n = 0;
    pend = 1'b0;
    for (int k = 0; k < 3000 && n < 80; k++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = ($urandom_range(0, 4) == 0) ?
                        {4'hF, 4'($urandom)} : {4'h0, 4'($urandom)};
        bus.cmd_wdata = 8'($urandom);
        pend = 1'b1;
      end
      bus.cmd_valid = pend;
      if (pend && bus.cmd_ready) begin
        model_cmd(bus.cmd_write, bus.cmd_addr, bus.cmd_wdata);
        n++;
        pend = 1'b0;
      end
      step();
    end
    bus.cmd_valid = 1'b0;
    check("rnd_issued", n, 80);
    compare_all("rnd", 12);
    cfg_rand = 1'b0;

`ifdef APB_TIMEOUT_EN
    cfg_mem   = 1'b0;
    cfg_wait  = 100;
    cfg_rdata = 8'hE7;
    cfg_err   = 1'b0;
    run_one(1'b0, 8'h44, 8'h00, lat, pen);
    check("to_latency", lat, 18);
    check("to_access_cycles", pen, 16);
    if (got.size() != 0) begin
      check("to_rsp_err", got[0].err, 1);
      check("to_rsp_timeout", got[0].to, 1);
      check("to_rsp_rdata", got[0].rd, 0);
    end
    step();
    check("to_psel_drop", bus.psel, 0);
    repeat (3) step();
    cfg_wait  = 15;
    cfg_rdata = 8'h5E;
    run_one(1'b0, 8'h45, 8'h00, lat, pen);
    check("edge_latency", lat, 18);
    check("edge_access_cycles", pen, 16);
    if (got.size() != 0) begin
      check("edge_rsp_err", got[0].err, 0);
      check("edge_rsp_timeout", got[0].to, 0);
      check("edge_rsp_rdata", got[0].rd, 8'h5E);
    end
    repeat (3) step();
`endif

    // reset during ACCESS aborts silently
    cfg_mem  = 1'b0;
    cfg_wait = 12;
    got.delete();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h66;
    bus.cmd_wdata = 8'h99;
    step();
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 10 && !bus.penable; k++) step();
    check("mid_in_access", bus.penable, 1);
    step();
    preset = 1'b1;
    step();
    check("mid_rst_psel", bus.psel, 0);
    check("mid_rst_pen", bus.penable, 0);
    check("mid_rst_busy", bus.busy, 0);
    preset = 1'b0;
    repeat (30) step();
    check("mid_rst_norsp", got.size(), 0);
    check("mid_rst_idle", bus.psel, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
